i2c_master: RTL and testbench

Single-byte I2C bus master that drives the open-drain `sda`/`scl` pair of the on-board I2C slave (address 7'b1010101). A host request is captured and sent as START, a 7-bit address with R/W bit, one data byte, and STOP. Write transfers deliver one byte to the slave. Read transfers return one byte to the host. The block sits directly upstream of the slave on the shared bus and is the only master on it.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_clk_div.sv | 44 ++++
 rtl/i2c_master.sv | 174 +++++++++++++++++
 tb/tb_i2c_master.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants for the single-byte I2C master
// Purpose: FSM state encoding, quarter-phase encoding, slave address and
//          byte width, shared by the master RTL and the slave-side bus model.
// Ports:   none (package).
package i2c_pkg;
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_START    = 4'd1;
    localparam logic [3:0] ST_ADDR     = 4'd2;
    localparam logic [3:0] ST_ADDR_ACK = 4'd3;
    localparam logic [3:0] ST_WDATA    = 4'd4;
    localparam logic [3:0] ST_WACK     = 4'd5;
    localparam logic [3:0] ST_RDATA    = 4'd6;
    localparam logic [3:0] ST_RNACK    = 4'd7;
    localparam logic [3:0] ST_STOP     = 4'd8;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [6:0] ADDRESS_SLAVE = 7'b1010101;
    localparam int         BITS_PER_BYTE = 8;
endpackage

// File: rtl/i2c_clk_div.sv
// rtl/i2c_clk_div.sv - quarter-period tick generator for the I2C master
// Purpose: emits a one-cycle tick every DIVIDER clocks and counts quarters
//          q0..q3 of a bit slot; held cleared while hold_i is high so each
//          transfer starts phase-aligned.
// Ports:   clk_i, rst_i (async, active-high), hold_i (sync clear),
//          tick_o (one-cycle quarter boundary), quarter_o (current quarter).
module i2c_clk_div #(
    parameter int DIVIDER = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    output logic       tick_o,
    output logic [1:0] quarter_o
);
    localparam int CW = $clog2(DIVIDER);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    quarter_q, quarter_d;

    // Last clock of the current quarter; the next edge opens a new quarter.
    assign tick_o    = (cnt_q == CNT_LAST);
    assign quarter_o = quarter_q;

    always_comb begin
        cnt_d     = tick_o ? '0 : cnt_q + CW'(1);
        quarter_d = tick_o ? quarter_q + 2'd1 : quarter_q;
        if (hold_i) begin
            cnt_d     = '0;
            quarter_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            quarter_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end
endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte open-drain I2C bus master
// Purpose: on an accepted start, sends START, {addr, rw}, one data byte
//          (write) or receives one byte (read, master NACKs), then STOP.
// Ports:   clk, rst (async, active-high), sda/scl (open-drain, 0 or Z),
//          start/addr/rw/data_write_master (request, sampled while ready),
//          data_read_master (last byte read), ready (idle), done (pulse in
//          last STOP cycle), ack_error (address or write byte NACKed).
module i2c_master
    import i2c_pkg::*;
#(
    parameter int DIVIDER = 4
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        sda,
    inout  wire        scl,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_write_master,
    output logic [7:0] data_read_master,
    output logic       ready,
    output logic       done,
    output logic       ack_error
);
    localparam logic [2:0] BIT_LAST = 3'(BITS_PER_BYTE - 1);

    logic [3:0] state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rw_q, rw_d;
    logic       samp_q, samp_d;
    logic       ack_error_q, ack_error_d;

    logic       tick;
    logic [1:0] quarter;
    logic       sample, slot_end;
    logic       sda_low, scl_low;

    i2c_clk_div #(.DIVIDER(DIVIDER)) u_clk_div (
        .clk_i     (clk),
        .rst_i     (rst),
        .hold_i    (state_q == ST_IDLE),
        .tick_o    (tick),
        .quarter_o (quarter)
    );

    // SDA is sampled on the q2->q3 boundary, mid-way through SCL high.
    assign sample   = tick && (quarter == Q2);
    assign slot_end = tick && (quarter == Q3);

    assign ready            = (state_q == ST_IDLE);
    assign done             = (state_q == ST_STOP) && slot_end;
    assign ack_error        = ack_error_q;
    assign data_read_master = rdata_q;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rw_d        = rw_q;
        samp_d      = samp_q;
        ack_error_d = ack_error_q;

        if (sample) begin
            samp_d = sda;
            if (state_q == ST_RDATA) shift_d = {shift_q[6:0], sda};
        end

        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d     = ST_START;
                shift_d     = {addr, rw};
                rw_d        = rw;
                wdata_d     = data_write_master;
                bit_d       = '0;
                ack_error_d = 1'b0;
            end
        end else if (slot_end) begin
            case (state_q)
                ST_START: begin
                    state_d = ST_ADDR;
                    bit_d   = '0;
                end
                ST_ADDR: begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) state_d = ST_ADDR_ACK;
                end
                ST_ADDR_ACK: begin
                    bit_d = '0;
                    if (samp_q) begin
                        ack_error_d = 1'b1;
                        state_d     = ST_STOP;
                    end else if (rw_q) begin
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_WDATA;
                        shift_d = wdata_q;
                    end
                end
                ST_WDATA: begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) state_d = ST_WACK;
                end
                ST_WACK: begin
                    if (samp_q) ack_error_d = 1'b1;
                    state_d = ST_STOP;
                end
                ST_RDATA: begin
                    bit_d = bit_q + 3'd1;
                    // Last bit was shifted in at the sample point of this slot.
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_RNACK;
                        rdata_d = shift_q;
                    end
                end
                ST_RNACK: state_d = ST_STOP;
                ST_STOP:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Line drive decoded from registered state and quarter only, so both
    // lines are released the moment the async reset returns the FSM to IDLE.
    always_comb begin
        sda_low = 1'b0;
        scl_low = 1'b0;
        case (state_q)
            ST_START: sda_low = quarter[1];
            ST_ADDR, ST_WDATA: begin
                sda_low = ~shift_q[7];
                scl_low = ~quarter[1];
            end
            ST_ADDR_ACK, ST_WACK, ST_RDATA, ST_RNACK: scl_low = ~quarter[1];
            ST_STOP: begin
                sda_low = ~quarter[1];
                scl_low = (quarter == Q0);
            end
            default: ;
        endcase
    end

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rw_q        <= 1'b0;
            samp_q      <= 1'b1;
            ack_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rw_q        <= rw_d;
            samp_q      <= samp_d;
            ack_error_q <= ack_error_d;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - self-checking bench for i2c_master with a bus-model slave
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int DIV      = 4;
    localparam int LAT_FULL = 80 * DIV;
    localparam int LAT_NACK = 44 * DIV;

    typedef struct {
        logic       rw;
        logic [7:0] byte_exp;
        logic       ack_err;
        int         lat;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr  = '0;
    logic       rw    = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       ready, done, ack_error;
    wire        sda, scl;

    pullup (sda);
    pullup (scl);

    logic slv_low = 1'b0;
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master #(.DIVIDER(DIV)) dut (
        .clk               (clk),
        .rst               (rst),
        .sda               (sda),
        .scl               (scl),
        .start             (start),
        .addr              (addr),
        .rw                (rw),
        .data_write_master (wdata),
        .data_read_master  (rdata),
        .ready             (ready),
        .done              (done),
        .ack_error         (ack_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    // Bus-model slave and protocol monitor, sampled on the falling clock edge.
    bit         mon_en = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    bit         active = 1'b0, addressed = 1'b0, is_read = 1'b0;
    int         bcnt = 0;
    logic [7:0] sh = '0, rd_byte = '0, got_byte = '0;
    logic       mack = 1'b0;
    int         got_cnt = 0, start_ev = 0, stop_ev = 0, proto_err = 0, stop_bcnt = 0;

    task automatic model_step();
        logic cs, cd;
        int   k;
        cs = scl;
        cd = sda;
        if (rst || !mon_en) begin
            active  = 1'b0;
            slv_low = 1'b0;
        end else if (prev_scl && cs && prev_sda && !cd) begin
            start_ev++;
            if (active) proto_err++;
            active  = 1'b1;
            bcnt    = 0;
            slv_low = 1'b0;
        end else if (prev_scl && cs && !prev_sda && cd) begin
            stop_ev++;
            // STOP is legal only after the address ACK slot or the data ACK slot
            // (plus the SCL rise inside the STOP slot itself).
            if (!active || (bcnt != 10 && bcnt != 19)) proto_err++;
            stop_bcnt = bcnt;
            active    = 1'b0;
            slv_low   = 1'b0;
        end else if (active && !prev_scl && cs) begin
            sh = {sh[6:0], cd};
            bcnt++;
            if (bcnt == 18 && is_read) mack = cd;
            if (bcnt == 17 && addressed && !is_read) begin
                got_byte = sh;
                got_cnt++;
            end
        end else if (active && prev_scl && !cs) begin
            k = bcnt;
            if (k == 8) begin
                addressed = (sh[7:1] == ADDRESS_SLAVE);
                is_read   = sh[0];
                slv_low   = addressed;
            end else if (k >= 9 && k <= 16 && addressed && is_read) begin
                slv_low = ~rd_byte[16 - k];
            end else if (k == 17 && addressed && !is_read) begin
                slv_low = 1'b1;
            end else begin
                slv_low = 1'b0;
            end
        end
        prev_scl = cs;
        prev_sda = cd;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: ready never rose within 2000 cycles");
        end
        addr = a; rw = r; wdata = w; start = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done within 2000 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (ack_error !== 1'b0) begin n_err++; $display("FAIL rst_ack_error: got %b expected 0", ack_error); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rst_sda: got %b expected released 1", sda); end
        n_cmp++; if (scl !== 1'b1) begin n_err++; $display("FAIL rst_scl: got %b expected released 1", scl); end
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        exp_t e; int lat; int g0;
        g0 = got_cnt;
        issue(7'h55, 1'b0, 8'hA5);
        sb.push_back('{1'b0, 8'hA5, 1'b0, LAT_FULL});
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL wr_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (ack_error !== e.ack_err) begin n_err++; $display("FAIL wr_ack_error: got %b expected %b", ack_error, e.ack_err); end
        n_cmp++; if (got_byte !== e.byte_exp) begin n_err++; $display("FAIL wr_slave_byte: got %h expected %h", got_byte, e.byte_exp); end
        n_cmp++; if (got_cnt !== g0 + 1) begin n_err++; $display("FAIL wr_slave_count: got %0d expected %0d", got_cnt, g0 + 1); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_at_done: got %b expected 0", ready); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_after: got %b expected 1", ready); end
        n_cmp++; if (stop_bcnt !== 19) begin n_err++; $display("FAIL wr_stop_pos: got %0d expected 19", stop_bcnt); end
    endtask

    task automatic test_read();
        exp_t e; int lat;
        rd_byte = 8'h3C;
        mack = 1'b0;
        issue(7'h55, 1'b1, 8'h00);
        sb.push_back('{1'b1, 8'h3C, 1'b0, LAT_FULL});
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL rd_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (rdata !== e.byte_exp) begin n_err++; $display("FAIL rd_data: got %h expected %h", rdata, e.byte_exp); end
        n_cmp++; if (ack_error !== e.ack_err) begin n_err++; $display("FAIL rd_ack_error: got %b expected %b", ack_error, e.ack_err); end
        n_cmp++; if (mack !== 1'b1) begin n_err++; $display("FAIL rd_master_nack: sda in 9th data slot got %b expected 1", mack); end
        n_cmp++; if (stop_bcnt !== 19) begin n_err++; $display("FAIL rd_stop_pos: got %0d expected 19", stop_bcnt); end
    endtask

    task automatic test_addr_nack();
        exp_t e; int lat; int g0;
        g0 = got_cnt;
        issue(7'h12, 1'b0, 8'h77);
        sb.push_back('{1'b0, 8'h00, 1'b1, LAT_NACK});
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL nack_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (ack_error !== e.ack_err) begin n_err++; $display("FAIL nack_ack_error: got %b expected %b", ack_error, e.ack_err); end
        n_cmp++; if (stop_bcnt !== 10) begin n_err++; $display("FAIL nack_stop_pos: got %0d expected 10", stop_bcnt); end
        n_cmp++; if (got_cnt !== g0) begin n_err++; $display("FAIL nack_slave_count: got %0d expected %0d", got_cnt, g0); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; int g0;
        g0 = got_cnt;
        issue(7'h55, 1'b0, 8'h5A);
        sb.push_back('{1'b0, 8'h5A, 1'b0, LAT_FULL});
        // Keep start asserted through the whole first transfer with new data.
        start = 1'b1;
        wdata = 8'hC3;
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL b2b_lat1: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (got_byte !== e.byte_exp) begin n_err++; $display("FAIL b2b_byte1: got %h expected %h", got_byte, e.byte_exp); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_at_done: got %b expected 0", ready); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after: got %b expected 1", ready); end
        acc_cyc = cyc;
        sb.push_back('{1'b0, 8'hC3, 1'b0, LAT_FULL});
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL b2b_lat2: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (got_byte !== e.byte_exp) begin n_err++; $display("FAIL b2b_byte2: got %h expected %h", got_byte, e.byte_exp); end
        n_cmp++; if (got_cnt !== g0 + 2) begin n_err++; $display("FAIL b2b_count: got %0d expected %0d", got_cnt, g0 + 2); end
    endtask

    task automatic test_busy_ignore();
        exp_t e; int lat; int s0; int g0;
        s0 = start_ev;
        g0 = got_cnt;
        issue(7'h55, 1'b0, 8'h96);
        sb.push_back('{1'b0, 8'h96, 1'b0, LAT_FULL});
        repeat (100) @(negedge clk);
        addr = 7'h12; rw = 1'b1; wdata = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL busy_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (got_byte !== e.byte_exp) begin n_err++; $display("FAIL busy_byte: got %h expected %h", got_byte, e.byte_exp); end
        n_cmp++; if (ack_error !== e.ack_err) begin n_err++; $display("FAIL busy_ack_error: got %b expected %b", ack_error, e.ack_err); end
        repeat (20) @(negedge clk);
        n_cmp++; if (start_ev !== s0 + 1) begin n_err++; $display("FAIL busy_start_count: got %0d expected %0d", start_ev, s0 + 1); end
        n_cmp++; if (got_cnt !== g0 + 1) begin n_err++; $display("FAIL busy_slave_count: got %0d expected %0d", got_cnt, g0 + 1); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL busy_ready_idle: got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat;
        issue(7'h55, 1'b0, 8'h00);
        // WDATA bit 3 occupies slot 13; cycle 210 lies in its q0 (both lines low).
        while (cyc < acc_cyc + 13 * 4 * DIV + 2) @(negedge clk);
        n_cmp++; if (scl !== 1'b0) begin n_err++; $display("FAIL mid_scl_driven: got %b expected 0", scl); end
        n_cmp++; if (sda !== 1'b0) begin n_err++; $display("FAIL mid_sda_driven: got %b expected 0", sda); end
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (scl !== 1'b1) begin n_err++; $display("FAIL mid_scl_release: got %b expected 1", scl); end
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL mid_sda_release: got %b expected 1", sda); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b expected 1", ready); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL mid_rdata: got %h expected 00", rdata); end
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        issue(7'h55, 1'b0, 8'hC3);
        sb.push_back('{1'b0, 8'hC3, 1'b0, LAT_FULL});
        wait_done(lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL post_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (got_byte !== e.byte_exp) begin n_err++; $display("FAIL post_byte: got %h expected %h", got_byte, e.byte_exp); end
        n_cmp++; if (ack_error !== e.ack_err) begin n_err++; $display("FAIL post_ack_error: got %b expected %b", ack_error, e.ack_err); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        repeat (4) @(negedge clk);
        n_cmp++; if (proto_err !== 0) begin n_err++; $display("FAIL protocol: got %0d bus violations expected 0", proto_err); end
        n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
